// File: rtl/lvds_sync_decoder.sv
// Receive-side framing for the aligned LVDS word stream: strips four-word sync
// headers (ones, zero, zero, code) and emits qualified pixels with line/frame framing.
//
// state | meaning
// IDLE  | waiting for SOF; pixel output disabled
// FRAME | inside a frame, between lines
// LINE  | inside a line; non-header words are valid pixels
module lvds_sync_decoder #(
    parameter int                    DATA_WIDTH = 10,
    parameter logic [DATA_WIDTH-1:0] SOF_CODE   = 10'h2AC,
    parameter logic [DATA_WIDTH-1:0] EOF_CODE   = 10'h2D8,
    parameter logic [DATA_WIDTH-1:0] SOL_CODE   = 10'h200,
    parameter logic [DATA_WIDTH-1:0] EOL_CODE   = 10'h274,
    parameter int                    CNT_WIDTH  = 12,
    parameter int                    MAX_PIXELS = 4095
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] tdata,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_valid,
    output logic                  line_valid,
    output logic                  frame_valid,
    output logic                  frame_start,
    output logic                  line_done,
    output logic                  frame_done,
    output logic [CNT_WIDTH-1:0]  pix_count,
    output logic [CNT_WIDTH-1:0]  line_count,
    output logic                  sync_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        LINE  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] PIX_LAST = CNT_WIDTH'(MAX_PIXELS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = '1;

    state_t                state;
    logic [DATA_WIDTH-1:0] s [4];
    logic [1:0]            hdr_cnt;
    logic                  hdr;
    logic                  pix_ok;
    logic [DATA_WIDTH-1:0] code;

    always_comb begin
        hdr    = (s[3] == '1) && (s[2] == '0) && (s[1] == '0);
        code   = s[0];
        pix_ok = (state == LINE) && !hdr && (hdr_cnt == 2'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) s[i] <= '0;
            hdr_cnt     <= 2'd0;
            state       <= IDLE;
            pix_data    <= '0;
            pix_valid   <= 1'b0;
            line_valid  <= 1'b0;
            frame_valid <= 1'b0;
            frame_start <= 1'b0;
            line_done   <= 1'b0;
            frame_done  <= 1'b0;
            sync_err    <= 1'b0;
            pix_count   <= '0;
            line_count  <= '0;
        end else begin
            s[0]     <= tdata;
            s[1]     <= s[0];
            s[2]     <= s[1];
            s[3]     <= s[2];
            pix_data <= s[3];

            // Suppress the header word and the three words behind it
            if (hdr)
                hdr_cnt <= 2'd3;
            else if (hdr_cnt != 2'd0)
                hdr_cnt <= hdr_cnt - 2'd1;

            frame_start <= 1'b0;
            line_done   <= 1'b0;
            frame_done  <= 1'b0;
            sync_err    <= 1'b0;
            pix_valid   <= 1'b0;

            if (!enable) begin
                state       <= IDLE;
                line_valid  <= 1'b0;
                frame_valid <= 1'b0;
                pix_count   <= '0;
                line_count  <= '0;
            end else begin
                pix_valid <= pix_ok;
                if (pix_ok) begin
                    pix_count <= pix_count + CNT_WIDTH'(1);
                    // Overlong line: abandon it without counting it
                    if (pix_count == PIX_LAST) begin
                        sync_err   <= 1'b1;
                        state      <= FRAME;
                        line_valid <= 1'b0;
                    end
                end

                if (hdr) begin
                    case (state)
                        IDLE: begin
                            if (code == SOF_CODE) begin
                                state       <= FRAME;
                                frame_valid <= 1'b1;
                                frame_start <= 1'b1;
                                line_count  <= '0;
                            end
                        end
                        FRAME: begin
                            if (code == SOL_CODE) begin
                                state      <= LINE;
                                line_valid <= 1'b1;
                                pix_count  <= '0;
                            end else if (code == EOF_CODE) begin
                                state       <= IDLE;
                                frame_valid <= 1'b0;
                                frame_done  <= 1'b1;
                            end else if (code == SOF_CODE) begin
                                sync_err    <= 1'b1;
                                frame_start <= 1'b1;
                                line_count  <= '0;
                            end else begin
                                sync_err <= 1'b1;
                            end
                        end
                        LINE: begin
                            if (code == EOL_CODE) begin
                                state      <= FRAME;
                                line_valid <= 1'b0;
                                line_done  <= 1'b1;
                                if (line_count != CNT_FULL)
                                    line_count <= line_count + CNT_WIDTH'(1);
                            end else if (code == SOL_CODE) begin
                                sync_err  <= 1'b1;
                                pix_count <= '0;
                            end else if (code == SOF_CODE) begin
                                sync_err    <= 1'b1;
                                state       <= FRAME;
                                line_valid  <= 1'b0;
                                frame_start <= 1'b1;
                                line_count  <= '0;
                            end else if (code == EOF_CODE) begin
                                sync_err    <= 1'b1;
                                state       <= IDLE;
                                line_valid  <= 1'b0;
                                frame_valid <= 1'b0;
                            end else begin
                                sync_err <= 1'b1;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_lvds_sync_decoder.sv
// Directed bench for lvds_sync_decoder: framing, header stripping, error cases,
// enable gating and mid-line reset.
module tb_lvds_sync_decoder;

    localparam logic [9:0] SOF = 10'h2AC;
    localparam logic [9:0] EOF = 10'h2D8;
    localparam logic [9:0] SOL = 10'h200;
    localparam logic [9:0] EOL = 10'h274;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [9:0]  tdata;
    logic [9:0]  pix_data;
    logic        pix_valid, line_valid, frame_valid;
    logic        frame_start, line_done, frame_done, sync_err;
    logic [11:0] pix_count, line_count;

    int checks = 0;
    int errors = 0;

    logic [9:0] pq[$];
    int n_ld = 0, n_fd = 0, n_fs = 0, n_se = 0, n_active = 0;

    lvds_sync_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .tdata       (tdata),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .line_valid  (line_valid),
        .frame_valid (frame_valid),
        .frame_start (frame_start),
        .line_done   (line_done),
        .frame_done  (frame_done),
        .pix_count   (pix_count),
        .line_count  (line_count),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (pix_valid) pq.push_back(pix_data);
        if (line_done) n_ld++;
        if (frame_done) n_fd++;
        if (frame_start) n_fs++;
        if (sync_err) n_se++;
        if (pix_valid || line_valid || frame_valid || frame_start || line_done ||
            frame_done || sync_err || pix_count != 12'd0 || line_count != 12'd0)
            n_active++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [9:0] w);
        tdata = w;
        @(posedge clk);
        #2;
    endtask

    task automatic hdr_send(input logic [9:0] c);
        send(10'h3FF);
        send(10'h000);
        send(10'h000);
        send(c);
    endtask

    task automatic do_line(input int n, input logic [9:0] base, input logic exp_err,
                           input string tag);
        hdr_send(SOL);
        for (int i = 0; i < n; i++) begin
            send(base + 10'(i));
            if (i == 0) begin
                chk({tag, "_line_valid"}, 32'(line_valid), 32'd1);
                chk({tag, "_pix_count0"}, 32'(pix_count), 32'd0);
                chk({tag, "_sync_err"}, 32'(sync_err), 32'(exp_err));
            end
            if (i == 4) begin
                chk({tag, "_first_valid"}, 32'(pix_valid), 32'd1);
                chk({tag, "_first_data"}, 32'(pix_data), 32'(base));
            end
        end
        hdr_send(EOL);
        chk({tag, "_last_valid"}, 32'(pix_valid), 32'd1);
        chk({tag, "_last_data"}, 32'(pix_data), 32'(base + 10'(n - 1)));
        chk({tag, "_pix_count"}, 32'(pix_count), 32'(n));
    endtask

    initial begin
        int qs, a, se0, ld0;

        // Reset state
        reset = 1'b1; enable = 1'b1; tdata = 10'h0;
        send(10'h0);
        send(10'h0);
        chk("rst_flags", 32'({pix_valid, line_valid, frame_valid, frame_start,
                              line_done, frame_done, sync_err}), 32'd0);
        chk("rst_pix_data", 32'(pix_data), 32'd0);
        chk("rst_counts", 32'({pix_count, line_count}), 32'd0);
        reset = 1'b0;
        send(10'h0);

        // Frame of three 8-pixel lines, first EOL padded, the rest back-to-back
        qs = pq.size();
        hdr_send(SOF);
        send(10'h0);
        chk("t1_frame_start", 32'(frame_start), 32'd1);
        chk("t1_frame_valid", 32'(frame_valid), 32'd1);
        do_line(8, 10'h001, 1'b0, "t1_l1");
        send(10'h0);
        chk("t1_line_done", 32'(line_done), 32'd1);
        chk("t1_line_valid_fall", 32'(line_valid), 32'd0);
        chk("t1_line_count1", 32'(line_count), 32'd1);
        chk("t1_gap_valid", 32'(pix_valid), 32'd0);
        do_line(8, 10'h001, 1'b0, "t1_l2");
        do_line(8, 10'h001, 1'b0, "t1_l3");
        hdr_send(EOF);
        send(10'h0);
        chk("t1_frame_done", 32'(frame_done), 32'd1);
        chk("t1_frame_valid_fall", 32'(frame_valid), 32'd0);
        chk("t1_line_count3", 32'(line_count), 32'd3);
        send(10'h0);
        chk("t1_npix", 32'(pq.size() - qs), 32'd24);
        for (int i = 0; i < 24; i++)
            chk("t1_pix_order", 32'(pq[qs + i]), 32'((i % 8) + 1));
        chk("t1_n_line_done", 32'(n_ld), 32'd3);
        chk("t1_n_frame_done", 32'(n_fd), 32'd1);
        chk("t1_n_sync_err", 32'(n_se), 32'd0);

        // Partial preamble inside a line is plain pixel data
        qs = pq.size();
        hdr_send(SOF);
        hdr_send(SOL);
        send(10'h3FF); send(10'h000); send(10'h005);
        send(10'h3FF); send(10'h000); send(10'h001);
        hdr_send(EOL);
        chk("t2_pix_count", 32'(pix_count), 32'd6);
        send(10'h0);
        chk("t2_npix", 32'(pq.size() - qs), 32'd6);
        chk("t2_w0", 32'(pq[qs + 0]), 32'h3FF);
        chk("t2_w1", 32'(pq[qs + 1]), 32'h000);
        chk("t2_w2", 32'(pq[qs + 2]), 32'h005);
        chk("t2_w5", 32'(pq[qs + 5]), 32'h001);
        chk("t2_n_sync_err", 32'(n_se), 32'd0);

        // SOL inside a line after 5 pixels restarts the line
        qs = pq.size();
        se0 = n_se;
        hdr_send(SOL);
        for (int i = 0; i < 5; i++) send(10'h101 + 10'(i));
        do_line(8, 10'h201, 1'b1, "t3");
        hdr_send(EOF);
        send(10'h0);
        chk("t3_npix", 32'(pq.size() - qs), 32'd13);
        chk("t3_w4", 32'(pq[qs + 4]), 32'h105);
        chk("t3_w5", 32'(pq[qs + 5]), 32'h201);
        chk("t3_w12", 32'(pq[qs + 12]), 32'h208);
        chk("t3_n_sync_err", 32'(n_se - se0), 32'd1);

        // 4096-pixel line overruns MAX_PIXELS
        hdr_send(SOF);
        send(10'h0);
        do_line(2, 10'h0B0, 1'b0, "t4a");
        ld0 = n_ld + 1;
        hdr_send(SOL);
        for (int j = 1; j <= 4096; j++) send(10'(j) & 10'h1FF);
        send(10'h0); send(10'h0); send(10'h0);
        chk("t4_sync_err", 32'(sync_err), 32'd1);
        chk("t4_pix_count", 32'(pix_count), 32'd4095);
        chk("t4_last_valid", 32'(pix_valid), 32'd1);
        chk("t4_line_valid", 32'(line_valid), 32'd0);
        chk("t4_frame_valid", 32'(frame_valid), 32'd1);
        chk("t4_line_count", 32'(line_count), 32'd1);
        send(10'h0);
        chk("t4_after_valid", 32'(pix_valid), 32'd0);
        chk("t4_after_count", 32'(pix_count), 32'd4095);
        chk("t4_after_err", 32'(sync_err), 32'd0);
        chk("t4_no_line_done", 32'(n_ld), 32'(ld0));
        hdr_send(EOF);
        send(10'h0);
        chk("t4_frame_done", 32'(frame_done), 32'd1);

        // enable low for a whole frame, then rising mid-line
        enable = 1'b0;
        send(10'h0);
        chk("t5_counts_clear", 32'({pix_count, line_count}), 32'd0);
        a = n_active;
        qs = pq.size();
        hdr_send(SOF);
        hdr_send(SOL);
        for (int i = 0; i < 4; i++) send(10'h050 + 10'(i));
        hdr_send(EOL);
        hdr_send(EOF);
        send(10'h0);
        chk("t5_quiet_disabled", 32'(n_active - a), 32'd0);
        hdr_send(SOL);
        send(10'h061); send(10'h062);
        enable = 1'b1;
        send(10'h063); send(10'h064);
        hdr_send(EOL);
        send(10'h0);
        hdr_send(SOL);
        send(10'h071); send(10'h072); send(10'h073);
        hdr_send(EOL);
        send(10'h0);
        chk("t5_quiet_no_sof", 32'(n_active - a), 32'd0);
        chk("t5_no_pix", 32'(pq.size() - qs), 32'd0);
        // SOF header completes while disabled, enable rises before it is decoded
        enable = 1'b0;
        send(10'h3FF); send(10'h000); send(10'h000); send(SOF);
        enable = 1'b1;
        send(10'h0);
        chk("t5_late_sof", 32'(frame_start), 32'd1);
        do_line(3, 10'h0A0, 1'b0, "t5");
        hdr_send(EOF);
        send(10'h0);
        chk("t5_npix", 32'(pq.size() - qs), 32'd3);
        chk("t5_w0", 32'(pq[qs]), 32'h0A0);

        // Reset mid-line
        hdr_send(SOF);
        hdr_send(SOL);
        for (int i = 0; i < 6; i++) send(10'h0D0 + 10'(i));
        reset = 1'b1;
        send(10'h0D6);
        chk("t6_flags", 32'({pix_valid, line_valid, frame_valid, frame_start,
                             line_done, frame_done, sync_err}), 32'd0);
        chk("t6_pix_data", 32'(pix_data), 32'd0);
        chk("t6_counts", 32'({pix_count, line_count}), 32'd0);
        reset = 1'b0;
        a = n_active;
        send(10'h0D7); send(10'h0D8);
        hdr_send(EOL);
        send(10'h0);
        hdr_send(SOL);
        send(10'h0E1); send(10'h0E2);
        hdr_send(EOL);
        send(10'h0);
        chk("t6_quiet", 32'(n_active - a), 32'd0);
        hdr_send(SOF);
        send(10'h0);
        chk("t6_frame_start", 32'(frame_start), 32'd1);
        do_line(2, 10'h0C0, 1'b0, "t6");
        send(10'h0);
        chk("t6_line_count", 32'(line_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lvds_sync_decoder.md
# lvds_sync_decoder

Receive-side framing stage placed directly downstream of the LVDS receiver, in the `clkdiv` domain. It consumes the aligned parallel word stream once bitslip alignment has completed. It detects four-word sync headers (all-ones, zero, zero, code) and strips them. It emits qualified pixel words with line/frame framing, pixel and line counts, and protocol-error pulses.

## Interface
- `DATA_WIDTH`, 10, word width; must match the receiver deserialization width
- `SOF_CODE`, 10'h2AC, 4th header word marking start of frame
- `EOF_CODE`, 10'h2D8, 4th header word marking end of frame
- `SOL_CODE`, 10'h200, 4th header word marking start of line
- `EOL_CODE`, 10'h274, 4th header word marking end of line
- `CNT_WIDTH`, 12, width of `pix_count` and `line_count`
- `MAX_PIXELS`, 4095, maximum pixels per line; must be ≤ 2^CNT_WIDTH−1

Ports:
- `clk`  in  1  word clock (receiver `clkdiv`)
- `reset`  in  1  synchronous, active-high
- `enable`  in  1  decode enable; driven from receiver `bitslip_done`
- `tdata`  in  DATA_WIDTH  aligned word, one per `clk`
- `pix_data`  out  DATA_WIDTH  delayed word stream
- `pix_valid`  out  1  `pix_data` is an active pixel
- `line_valid`  out  1  high in state LINE
- `frame_valid`  out  1  high in states FRAME and LINE
- `frame_start`  out  1  1-cycle pulse on accepted SOF
- `line_done`  out  1  1-cycle pulse on accepted EOL
- `frame_done`  out  1  1-cycle pulse on accepted EOF
- `pix_count`  out  CNT_WIDTH  pixels output in current/last line
- `line_count`  out  CNT_WIDTH  lines completed in current/last frame
- `sync_err`  out  1  1-cycle pulse on protocol violation

## Operation
- Shift register `s[0..3]` (`s[0]` newest) loads `tdata` every cycle, including when `enable` is low.
- Header detect `hdr`: `s[3]` = all ones, `s[2]` = 0, and `s[1]` = 0. The code word is `s[0]`.
- `pix_data` <= `s[3]` every cycle.
- `pix_valid` <= (state == LINE) && no header suppression, where suppression covers the `hdr` cycle and the following 3 cycles (`hdr_cnt` loads 3).
- Header words are therefore never valid. Pixels preceding an EOL header have already left `s[3]` and are output.
- State machine:
  - **IDLE**
    - SOF → FRAME, `line_count` = 0, `frame_start`.
    - All other codes ignored.
  - **FRAME**
    - SOL → LINE, `pix_count` = 0.
    - EOF → IDLE, `frame_done`.
    - SOF → `sync_err`, then restart the frame: stay in FRAME, `line_count` = 0, `frame_start`.
    - EOL → `sync_err`, stay in FRAME.
  - **LINE**
    - EOL → FRAME, `line_count` +1 (saturating), `line_done`.
    - SOL → `sync_err`, restart the line: stay in LINE, `pix_count` = 0.
    - SOF → `sync_err`, restart the frame: enter FRAME, `line_count` = 0, `frame_start`.
    - EOF → `sync_err`, enter IDLE (no `frame_done`).
- An unknown code after a valid preamble in FRAME/LINE → `sync_err`, no state change. In IDLE it is ignored.
- `pix_count` increments with each `pix_valid`.
- When `pix_count` reaches `MAX_PIXELS` while in LINE with no EOL → `sync_err`, enter FRAME. No `line_done`, no `line_count` increment.
- `enable` low forces IDLE and clears all outputs except `pix_data`. `pix_count` and `line_count` are also cleared.

## Timing
- Reset value of every output and of `s[*]` is 0, with state IDLE. A reset mid-line aborts without any pulse.
- Word latency: a word on `tdata` at edge m appears on `pix_data` at edge m+4.
- Let the code word be sampled at edge k. Then:
  - At edge k+1: state update, pulses, `sync_err` and `line_valid`/`frame_valid` changes are visible.
  - The first pixel after SOL (tdata edge k+1) is valid at edge k+5.
  - The last pixel before EOL (tdata edge k−4) is valid at edge k. `line_valid` falls at edge k+1.
- `pix_count` and `line_count` update on the same edge as the triggering `pix_valid` or pulse. Both hold their values through FRAME/IDLE until the next SOL or SOF.
- Back-to-back headers (EOL immediately followed by SOL) must decode correctly, with no pixels emitted between them.
- `enable` rising mid-stream: decode begins on the next `hdr`. A header already in `s` qualifies.

## Test plan
- Reset, `enable`=1, SOF, then 3× {SOL, 8 pixels 0x001..0x008, EOL}, then EOF → 24 `pix_valid` words, in order, at latency 4. `line_done` ×3, `line_count`=3, `frame_done` once, and `pix_count`=8 after each line.
- A pixel 0x3FF, 0x000 pair inside a line not followed by the second 0x000 → no detect, and all words are output valid.
- SOL while in LINE after 5 pixels → `sync_err` pulse, `pix_count` restarts at 0, and the following line's pixels are valid.
- 4096-pixel line with `MAX_PIXELS`=4095 → `sync_err` at count 4095, state FRAME, `line_count` unchanged.
- `enable` held low while a full frame is sent → all outputs stay 0. `enable` rises mid-line → nothing is valid until the next SOF then SOL.
- `reset` asserted mid-line → next edge all outputs 0, state IDLE. Frame decode resumes only after a new SOF.
